mac_lane_accum: RTL
===================

// Module: mac_lane_accum
// PURPOSE
//  Multi-lane successor to the single-lane MAC accumulate stage of the matrix-multiply datapath (C = A x B).
//  Takes LANES products per beat over a valid/ready handshake and keeps one accumulator per lane.
//  Counts k, row and column internally and writes LANES results of C per completed dot product.
//  Optional signed arithmetic and saturation; pulses mac_done when the whole M x N result is written.
// PARAMETERS
//  M                        4    rows of A / C
//  K                        4    inner dimension (beats per dot product), >= 2
//  N                        4    cols of B / C; must be a multiple of LANES
//  LANES                    2    parallel output columns per beat
//  DATA_WIDTH_INIT_MATRIX   32   element width of A and B
//  DATA_WIDTH_RESULT_MATRIX 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)   C element width (R)
//  SIGNED                   0    1: products/results two's complement; 0: unsigned
//  SATURATE                 0    1: clamp to R-bit range; 0: wrap (mod 2^R)
// PORTS
//  clk          in   1                     clock, all logic on rising edge
//  reset        in   1                     asynchronous, active-high reset
//  start        in   1                     one-cycle pulse; begins a new matrix, honoured only in IDLE
//  prod_valid   in   1                     product beat valid
//  prod_ready   out  1                     block accepts beat this cycle
//  product_reg  in   LANES*2*DATA_WIDTH_INIT_MATRIX   lane l at bits [l*2W +: 2W]
//  data_out_c   out  LANES*R               lane l result at [l*R +: R]
//  matrix_c_we  out  1                     write request; held until matrix_c_ready
//  matrix_c_ready in 1                     C memory accepts write this cycle
//  row_addr_c   out  $clog2(M)             C row of current write
//  col_addr_c   out  $clog2(N)             C column of lane 0; lane l writes col_addr_c+l
//  mac_done     out  1                     one-cycle pulse after final write accepted
// BEHAVIOUR
//  Reset: state IDLE; k, row, col counters, accumulators, data_out_c, row/col_addr_c = 0;
//   matrix_c_we, prod_ready, mac_done = 0. Reset mid-operation aborts; no write is completed.
//  States: IDLE -start-> ACCUM; ACCUM -final beat of last tile-> DRAIN; DRAIN -last write accepted-> DONE;
//   DONE -> IDLE (1 cycle, mac_done=1).
//  prod_ready = (state==ACCUM) && (!matrix_c_we || matrix_c_ready). Beat taken when prod_valid && prod_ready.
//  Accumulate per lane: k==0 loads acc=ext(p) (no clear cycle); else acc=acc+ext(p). ext = sign- or zero-extend
//   to R+1 bits per SIGNED; internal sum kept at R+1 bits.
//  Beat with k==K-1: data_out_c <= fmt(acc+p), row/col_addr_c <= current row/col, matrix_c_we <= 1 next cycle
//   (1-cycle latency from last beat to write request); k wraps to 0; col += LANES, at N wraps to 0 and row++.
//  fmt: SATURATE=1 clamps to [0,2^R-1] (unsigned) or [-2^(R-1),2^(R-1)-1] (signed); SATURATE=0 truncates to R bits.
//  matrix_c_we drops the cycle after matrix_c_ready seen; data/addr stable while we held.
//  Back-to-back: last beat of next tile may arrive in the same cycle the pending write is accepted (no bubble).
//  Final tile (row==M-1, col==N-LANES, k==K-1): go to DRAIN, prod_ready=0; when that write accepted -> DONE.
//  start outside IDLE ignored; prod_valid outside ACCUM ignored (prod_ready=0); matrix_c_ready with we=0 ignored.
//  Counters not cleared between matrices except by start (start resets k, row, col to 0).
// TESTING
//  1 M=K=N=4,LANES=2: A=I, B all 3, c_ready=1 -> 8 writes, every lane value 3, mac_done 1 cycle after 8th write.
//  2 Same, c_ready low 5 cycles at write 2 -> matrix_c_we held, data stable, prod_ready=0 until accepted.
//  3 SIGNED=1, products -5,+2,-1,-4 on lane0 -> data_out_c lane0 = -8 (R-bit two's complement).
//  4 R=8, SATURATE=1, unsigned products 200 x4 -> 255; SATURATE=0 -> 800 mod 256 = 32.
//  5 reset asserted at k=2 of tile 3 -> all outputs 0 next edge; new start recomputes C from row 0 col 0.
//  6 start pulsed in ACCUM and prod_valid in IDLE -> no effect on counters/accumulators.

Source files
------------

// File: rtl/mac_lane_accum.sv
// mac_lane_accum -- multi-lane MAC accumulate stage for C = A x B.
// Accepts LANES products per beat over a valid/ready handshake. Each lane keeps
// its own accumulator. The block counts k/row/col internally, and every
// completed dot product raises a held write request for LANES results of C.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   start                begins a new matrix (IDLE only)
//   prod_valid/ready     product beat handshake
//   product_reg          LANES products, lane l at [l*2W +: 2W]
//   data_out_c           LANES results, lane l at [l*R +: R]
//   matrix_c_we/ready    C write request / accept
//   row_addr_c/col_addr_c C write row, column of lane 0
//   mac_done             one-cycle pulse after the final write is accepted

// One lane: accumulate, then format the completed dot product.
module mac_lane_accum_lane #(
  parameter int PW       = 64,
  parameter int AW       = 67,
  parameter int RW       = 66,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_take,
  input  logic          i_first,
  input  logic          i_last,
  input  logic [PW-1:0] i_prod,
  output logic [RW-1:0] o_res
);
  logic [AW-1:0] r_acc, w_ext, w_sum;
  logic [RW-1:0] r_res, w_fmt;

  always_comb begin
    w_ext = {{(AW-PW){(SIGNED != 0) && i_prod[PW-1]}}, i_prod};
    // First beat loads the product directly, so no clear cycle is needed.
    w_sum = (i_first ? '0 : r_acc) + w_ext;
    w_fmt = w_sum[RW-1:0];
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        // In range iff every bit from RW-1 upward equals the sign bit.
        if (!(w_sum[AW-1:RW-1] == '0 || w_sum[AW-1:RW-1] == '1))
          w_fmt = w_sum[AW-1] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
      end else if (|w_sum[AW-1:RW]) begin
        w_fmt = '1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_res <= '0;
    end else if (i_take) begin
      r_acc <= w_sum;
      if (i_last) r_res <= w_fmt;
    end
  end

  assign o_res = r_res;
endmodule

module mac_lane_accum #(
  parameter int M                        = 4,
  parameter int K                        = 4,
  parameter int N                        = 4,
  parameter int LANES                    = 2,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K),
  parameter int SIGNED                   = 0,
  parameter int SATURATE                 = 0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        prod_valid,
  output logic                                        prod_ready,
  input  logic [LANES*2*DATA_WIDTH_INIT_MATRIX-1:0]   product_reg,
  output logic [LANES*DATA_WIDTH_RESULT_MATRIX-1:0]   data_out_c,
  output logic                                        matrix_c_we,
  input  logic                                        matrix_c_ready,
  output logic [$clog2(M)-1:0]                        row_addr_c,
  output logic [$clog2(N)-1:0]                        col_addr_c,
  output logic                                        mac_done
);
  localparam int PW  = 2*DATA_WIDTH_INIT_MATRIX;
  localparam int RW  = DATA_WIDTH_RESULT_MATRIX;
  localparam int KW  = $clog2(K);
  localparam int RAW = $clog2(M);
  localparam int CW  = $clog2(N);
  // Internal sum is R+1 bits for the default R; a narrower overridden R still
  // gets enough headroom that saturation sees the true sum.
  localparam int AW  = ((PW + KW) > RW ? (PW + KW) : RW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [KW-1:0]  r_k;
  logic [RAW-1:0] r_row, r_row_addr;
  logic [CW-1:0]  r_col, r_col_addr;
  logic           r_we;
  logic           w_take, w_klast, w_final;

  assign prod_ready = (r_state == S_ACCUM) && (!r_we || matrix_c_ready);
  assign w_take     = prod_valid && prod_ready;
  assign w_klast    = w_take && (r_k == KW'(K-1));
  assign w_final    = w_klast && (r_row == RAW'(M-1)) && (r_col == CW'(N-LANES));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_final) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_we && matrix_c_ready) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_we       <= 1'b0;
      r_row_addr <= '0;
      r_col_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) begin
        r_k   <= '0;
        r_row <= '0;
        r_col <= '0;
      end else if (w_take) begin
        if (w_klast) begin
          r_k <= '0;
          if (r_col == CW'(N-LANES)) begin
            r_col <= '0;
            r_row <= (r_row == RAW'(M-1)) ? '0 : r_row + RAW'(1);
          end else begin
            r_col <= r_col + CW'(LANES);
          end
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
      // A new request may replace one being accepted this same cycle.
      if (w_klast) begin
        r_we       <= 1'b1;
        r_row_addr <= r_row;
        r_col_addr <= r_col;
      end else if (matrix_c_ready) begin
        r_we <= 1'b0;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane_accum_lane #(
      .PW(PW), .AW(AW), .RW(RW), .SIGNED(SIGNED), .SATURATE(SATURATE)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_take  (w_take),
      .i_first (r_k == '0),
      .i_last  (w_klast),
      .i_prod  (product_reg[l*PW +: PW]),
      .o_res   (data_out_c[l*RW +: RW])
    );
  end

  assign matrix_c_we = r_we;
  assign row_addr_c  = r_row_addr;
  assign col_addr_c  = r_col_addr;
  assign mac_done    = (r_state == S_DONE);
endmodule
